meas_frontend: RTL
==================

MEAS_FRONTEND -- requirements
Module: meas_frontend

Interface
REQ-001 Parameter D_WIDTH, default 19, width of all signed fixed-point outputs.
REQ-002 Parameter Q_BITS, default 15, fractional bits of outputs (1.0 = 2^Q_BITS).
REQ-003 Parameter ADC_BITS, default 12, width of raw unsigned phase-current ADC codes.
REQ-004 Parameter CAL_LOG2, default 4, log2 of calibration sample count per channel.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rstb  input  1  reset, asynchronous, active-low.
REQ-007 adc_valid  input  1  one-cycle strobe; adc_a, adc_b, adc_angle valid this cycle.
REQ-008 adc_a, adc_b  input  ADC_BITS each  raw unsigned phase A/B current codes, midscale = zero current.
REQ-009 adc_angle  input  D_WIDTH  resolver angle, passed through unmodified.
REQ-010 cal_start  input  1  one-cycle pulse; starts/restarts offset calibration.
REQ-011 ready_in  input  1  downstream control core idle and accepting a sample.
REQ-012 currA_out, currB_out, currC_out  output  D_WIDTH each  signed Q(Q_BITS) phase currents.
REQ-013 angle_out  output  D_WIDTH  registered angle of the presented sample.
REQ-014 valid_out  output  1  sample presented; held until accepted.
REQ-015 cal_done  output  1  high in RUN state (offsets valid).
REQ-016 overrun_cnt  output  8  count of samples overwritten before acceptance, saturating.

Function
REQ-017 State machine SHALL have states IDLE, CAL, RUN; any state -> CAL on cal_start; CAL -> RUN after 2^CAL_LOG2 accepted adc_valid strobes; no other transitions.
REQ-018 In IDLE, adc_valid SHALL be ignored and valid_out SHALL stay 0.
REQ-019 In CAL, each adc_valid SHALL add adc_a / adc_b to separate (ADC_BITS+CAL_LOG2)-bit accumulators, cleared on entry to CAL; valid_out SHALL be 0 throughout CAL.
REQ-020 On CAL exit, offset_a/offset_b SHALL load accumulator >> CAL_LOG2 (truncating); RUN and cal_done=1 start the following cycle.
REQ-021 In RUN, adc_valid in cycle N SHALL load the holding register and assert valid_out in cycle N+1 (latency 1).
REQ-022 Conversion: currX = sign-extend(adc_X - offset_X, ADC_BITS+1 bits) << (Q_BITS - ADC_BITS + 1), widened to D_WIDTH; currC = -(currA + currB); no saturation required (range fits D_WIDTH=19).
REQ-023 Transfer SHALL occur on a rising edge where valid_out=1 and ready_in=1; valid_out SHALL clear next cycle unless a new sample loads the same cycle.
REQ-024 adc_valid coinciding with a transfer SHALL load the new sample, keep valid_out=1, no overrun increment.
REQ-025 adc_valid while valid_out=1 and no transfer SHALL overwrite the holding register with the newest sample and increment overrun_cnt, saturating at 255.
REQ-026 Outputs SHALL remain stable while valid_out=1 and not transferred, except per REQ-025.
REQ-027 cal_start in RUN SHALL drop valid_out next cycle and discard the held sample; overrun_cnt SHALL be kept.
REQ-028 cal_start during CAL SHALL clear accumulators and sample counter and restart the count.

Reset
REQ-029 rstb=0 SHALL immediately force state IDLE, valid_out=0, cal_done=0, all data outputs 0, overrun_cnt 0, accumulators 0, offsets 2^(ADC_BITS-1).
REQ-030 Reset asserted mid-CAL or mid-transfer SHALL abandon all work; no sample is presented after release until a new calibration completes.

Verification
REQ-031 Reset, 16 adc_valid with adc_a=2048, adc_b=2050 after cal_start -> cal_done=1, offsets 2048/2050, valid_out never high during CAL.
REQ-032 RUN, ready_in=1, adc_a=3072, adc_b=1026 (offsets 2048/2050) -> next cycle valid_out=1, currA=16384, currB=-16384, currC=0.
REQ-033 RUN, ready_in=0, three adc_valid strobes -> valid_out stays 1, outputs show third sample, overrun_cnt=2; ready_in=1 -> valid_out drops next cycle.
REQ-034 adc_valid on the same edge as a transfer -> valid_out stays 1, new data, overrun_cnt unchanged; 300 forced overruns -> overrun_cnt=255.
REQ-035 cal_start while valid_out=1 -> valid_out=0 next cycle, cal_done=0, recalibration over 16 fresh samples.
REQ-036 rstb pulsed low mid-CAL (asynchronously, between edges) -> outputs zero immediately, state IDLE, adc_valid ignored until cal_start.

Source files
------------

// File: rtl/meas_frontend.sv
// Phase-current measurement front end: ADC offset calibration, conversion to
// signed fixed point, and a one-deep holding register with overrun counting.
module meas_frontend #(
   parameter int D_WIDTH  = 19,
   parameter int Q_BITS   = 15,
   parameter int ADC_BITS = 12,
   parameter int CAL_LOG2 = 4
) (
   input  logic                clk,
   input  logic                rstb,
   input  logic                adc_valid,
   input  logic [ADC_BITS-1:0] adc_a,
   input  logic [ADC_BITS-1:0] adc_b,
   input  logic [D_WIDTH-1:0]  adc_angle,
   input  logic                cal_start,
   input  logic                ready_in,
   output logic [D_WIDTH-1:0]  currA_out,
   output logic [D_WIDTH-1:0]  currB_out,
   output logic [D_WIDTH-1:0]  currC_out,
   output logic [D_WIDTH-1:0]  angle_out,
   output logic                valid_out,
   output logic                cal_done,
   output logic [7:0]          overrun_cnt
);

   localparam int ACC_W = ADC_BITS + CAL_LOG2;
   localparam int SHIFT = Q_BITS - ADC_BITS + 1;
   localparam int EXT_W = D_WIDTH - ADC_BITS - 1;
   localparam logic [ADC_BITS-1:0] OFF_RST = {1'b1, {(ADC_BITS-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAL,
      S_RUN
   } state_t;

   state_t              r_state;
   logic [ACC_W-1:0]    r_acc_a;
   logic [ACC_W-1:0]    r_acc_b;
   logic [CAL_LOG2-1:0] r_cnt;
   logic [ADC_BITS-1:0] r_off_a;
   logic [ADC_BITS-1:0] r_off_b;

   logic [ACC_W-1:0]    w_acc_a_nxt;
   logic [ACC_W-1:0]    w_acc_b_nxt;
   logic [ADC_BITS:0]   w_diff_a;
   logic [ADC_BITS:0]   w_diff_b;
   logic [D_WIDTH-1:0]  w_curr_a;
   logic [D_WIDTH-1:0]  w_curr_b;
   logic [D_WIDTH-1:0]  w_curr_c;
   logic                w_xfer;

   assign w_acc_a_nxt = r_acc_a + ACC_W'(adc_a);
   assign w_acc_b_nxt = r_acc_b + ACC_W'(adc_b);

   // Zero-extend both operands one bit so the difference is a proper signed value.
   assign w_diff_a = {1'b0, adc_a} - {1'b0, r_off_a};
   assign w_diff_b = {1'b0, adc_b} - {1'b0, r_off_b};
   assign w_curr_a = {{EXT_W{w_diff_a[ADC_BITS]}}, w_diff_a} << SHIFT;
   assign w_curr_b = {{EXT_W{w_diff_b[ADC_BITS]}}, w_diff_b} << SHIFT;
   assign w_curr_c = -(w_curr_a + w_curr_b);

   assign w_xfer = valid_out & ready_in;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state     <= S_IDLE;
         r_acc_a     <= '0;
         r_acc_b     <= '0;
         r_cnt       <= '0;
         r_off_a     <= OFF_RST;
         r_off_b     <= OFF_RST;
         currA_out   <= '0;
         currB_out   <= '0;
         currC_out   <= '0;
         angle_out   <= '0;
         valid_out   <= 1'b0;
         cal_done    <= 1'b0;
         overrun_cnt <= '0;
      end else if (cal_start) begin
         // Restart from any state; the held sample is dropped but overruns are kept.
         r_state   <= S_CAL;
         r_acc_a   <= '0;
         r_acc_b   <= '0;
         r_cnt     <= '0;
         valid_out <= 1'b0;
         cal_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: ;
            S_CAL: begin
               if (adc_valid) begin
                  r_acc_a <= w_acc_a_nxt;
                  r_acc_b <= w_acc_b_nxt;
                  r_cnt   <= r_cnt + CAL_LOG2'(1);
                  if (r_cnt == '1) begin
                     r_off_a  <= w_acc_a_nxt[ACC_W-1 -: ADC_BITS];
                     r_off_b  <= w_acc_b_nxt[ACC_W-1 -: ADC_BITS];
                     r_state  <= S_RUN;
                     cal_done <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (adc_valid) begin
                  currA_out <= w_curr_a;
                  currB_out <= w_curr_b;
                  currC_out <= w_curr_c;
                  angle_out <= adc_angle;
                  valid_out <= 1'b1;
                  if (valid_out && !ready_in && overrun_cnt != 8'hFF) begin
                     overrun_cnt <= overrun_cnt + 8'd1;
                  end
               end else if (w_xfer) begin
                  valid_out <= 1'b0;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               valid_out <= 1'b0;
               cal_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
